// File: rtl/ticker_pkg.sv
// rtl/ticker_pkg.sv - shared encodings for the multi-rate ticker
package ticker_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  // Toggle mode flips on an event; pulse mode mirrors the event itself.
  function automatic logic next_clk_out(input mode_e mode, input logic cur, input logic ev);
    return (mode == MODE_PULSE) ? ev : (cur ^ ev);
  endfunction

endpackage

// File: rtl/ticker_channel.sv
// rtl/ticker_channel.sv - one tick channel: period register, counter, run/step FSM
module ticker_channel
  import ticker_pkg::*;
#(
  parameter int             W          = 32,
  parameter logic [W-1:0]   PERIOD_RST = W'(50_000_000)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic [W-1:0] period,
  input  logic         load,
  input  logic         sync,
  input  logic         step_req,
  output logic         step_ack,
  output logic         tick,
  output logic         clk_out
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] per_q, per_d;
  state_e       state_q, state_d;
  logic         tick_d, ack_d, clk_d;
  logic         terminal, step_go, event_go;

  always_comb begin
    cnt_d    = cnt_q;
    per_d    = per_q;
    state_d  = state_q;
    tick_d   = 1'b0;
    ack_d    = 1'b0;
    clk_d    = clk_out;
    event_go = 1'b0;
    terminal = en && (cnt_q >= per_q);
    step_go  = (state_q == IDLE) && step_req && !en;

    case (state_q)
      IDLE: begin
        if (en)
          state_d = RUN;
        else if (step_req)
          state_d = STEP;
      end
      RUN, STEP: state_d = en ? RUN : IDLE;
      default:   state_d = IDLE;
    endcase

    if (load)
      per_d = period;

    // sync and load both cancel any event this edge, including a pending step
    if (sync) begin
      cnt_d   = '0;
      clk_d   = 1'b0;
      state_d = en ? RUN : IDLE;
    end else if (load) begin
      cnt_d   = '0;
      state_d = en ? RUN : IDLE;
      if (en)
        clk_d = next_clk_out(mode_e'(mode), clk_out, 1'b0);
    end else begin
      event_go = terminal || step_go;
      if (event_go)
        cnt_d = '0;
      else if (en)
        cnt_d = cnt_q + W'(1);
      tick_d = event_go;
      ack_d  = step_go;
      if (en || step_go)
        clk_d = next_clk_out(mode_e'(mode), clk_out, event_go);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      per_q    <= PERIOD_RST;
      state_q  <= IDLE;
      tick     <= 1'b0;
      step_ack <= 1'b0;
      clk_out  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      state_q  <= state_d;
      tick     <= tick_d;
      step_ack <= ack_d;
      clk_out  <= clk_d;
    end
  end

endmodule

// File: rtl/multi_rate_ticker.sv
// rtl/multi_rate_ticker.sv - CH independent programmable tick/clock dividers
module multi_rate_ticker #(
  parameter int          CH         = 2,
  parameter int          W          = 32,
  parameter int unsigned PERIOD_RST = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   en,
  input  logic [CH-1:0]   mode,
  input  logic [CH*W-1:0] period,
  input  logic [CH-1:0]   load,
  input  logic            sync,
  input  logic [CH-1:0]   step_req,
  output logic [CH-1:0]   step_ack,
  output logic [CH-1:0]   tick,
  output logic [CH-1:0]   clk_out
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    ticker_channel #(
      .W          (W),
      .PERIOD_RST (W'(PERIOD_RST))
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .mode     (mode[i]),
      .period   (period[i*W +: W]),
      .load     (load[i]),
      .sync     (sync),
      .step_req (step_req[i]),
      .step_ack (step_ack[i]),
      .tick     (tick[i]),
      .clk_out  (clk_out[i])
    );
  end

endmodule

// File: tb/tb_multi_rate_ticker.sv
// tb/tb_multi_rate_ticker.sv - directed and randomized bench for multi_rate_ticker
module tb_multi_rate_ticker;

  localparam int          CH = 2;
  localparam int          W  = 8;
  localparam int unsigned PR = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   en, mode, load, step_req;
  logic [CH-1:0]   step_ack, tick, clk_out;
  logic [CH*W-1:0] period;
  logic            sync;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0]  m_cnt [CH];
  logic [W-1:0]  m_per [CH];
  logic [CH-1:0] m_tick, m_ack, m_clk, m_last_en, m_last_step;

  always #5 clk = ~clk;

  multi_rate_ticker #(.CH(CH), .W(W), .PERIOD_RST(PR)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .period   (period),
    .load     (load),
    .sync     (sync),
    .step_req (step_req),
    .step_ack (step_ack),
    .tick     (tick),
    .clk_out  (clk_out)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = '0;
      m_per[i] = W'(PR);
    end
    m_tick = '0; m_ack = '0; m_clk = '0; m_last_en = '0; m_last_step = '0;
  endtask

  // A channel is paused (able to step) when en was low last edge and last edge was not a step.
  task automatic model_step();
    for (int i = 0; i < CH; i++) begin
      logic idle, stp, ev;
      logic [W-1:0] slice;
      slice = period[i*W +: W];
      idle  = !m_last_en[i] && !m_last_step[i];
      stp   = idle && step_req[i] && !en[i];
      if (sync) begin
        m_cnt[i] = '0; m_clk[i] = 1'b0; m_tick[i] = 1'b0; m_ack[i] = 1'b0;
        m_last_step[i] = 1'b0;
        if (load[i]) m_per[i] = slice;
      end else if (load[i]) begin
        m_per[i] = slice; m_cnt[i] = '0; m_tick[i] = 1'b0; m_ack[i] = 1'b0;
        m_last_step[i] = 1'b0;
        if (en[i] && mode[i]) m_clk[i] = 1'b0;
      end else begin
        ev = (en[i] && m_cnt[i] >= m_per[i]) || stp;
        m_tick[i] = ev;
        m_ack[i]  = stp;
        m_last_step[i] = stp;
        if (ev) m_cnt[i] = '0;
        else if (en[i]) m_cnt[i] = m_cnt[i] + 1'b1;
        if (en[i] || stp) m_clk[i] = mode[i] ? ev : (m_clk[i] ^ ev);
      end
      m_last_en[i] = en[i];
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    chk("model_tick", tick, m_tick);
    chk("model_ack", step_ack, m_ack);
    chk("model_clk_out", clk_out, m_clk);
  endtask

  task automatic set_period(input int ch, input int val);
    period[ch*W +: W] = W'(val);
  endtask

  initial begin
    rst = 1'b1; en = '0; mode = '0; load = '0; sync = 1'b0; step_req = '0; period = '0;
    model_reset();
    repeat (2) cycle();
    chk("rst_tick", tick, 0);
    chk("rst_ack", step_ack, 0);
    chk("rst_clk_out", clk_out, 0);

    // period 3 toggle: tick every 4, clk_out period 8
    rst = 1'b0;
    en = 2'b01; set_period(0, 3); load = 2'b01;
    cycle();
    load = '0;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      chk("p3_tick", tick[0], (k % 4 == 0));
      chk("p3_clk_out", clk_out[0], ((k / 4) % 2));
    end

    // pause after two counts, then single step
    repeat (2) cycle();
    en = '0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("paused_tick", tick[0], 0);
    end
    step_req = 2'b01;
    cycle();
    chk("step_ack", step_ack[0], 1);
    chk("step_tick", tick[0], 1);
    step_req = '0; en = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk("after_step_tick", tick[0], (k == 4));
    end
    step_req = 2'b01;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("step_while_run_ack", step_ack[0], 0);
    end
    step_req = '0; en = '0;
    repeat (2) cycle();
    step_req = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk("held_step_ack", step_ack[0], (k % 2 == 1));
    end
    step_req = '0;

    // period 0: pulse mode solid high, then toggle every cycle
    en = 2'b10; mode = 2'b10; set_period(1, 0); load = 2'b10;
    cycle();
    load = '0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("p0_pulse_tick", tick[1], 1);
      chk("p0_pulse_clk_out", clk_out[1], 1);
    end
    mode = '0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk("p0_toggle_tick", tick[1], 1);
      chk("p0_toggle_clk_out", clk_out[1], (k % 2 == 0));
    end

    // load coincident with terminal count suppresses the tick
    en = 2'b01; set_period(0, 3); load = 2'b01;
    cycle();
    load = '0;
    repeat (3) cycle();
    set_period(0, 5); load = 2'b01;
    cycle();
    chk("load_wins_tick", tick[0], 0);
    load = '0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      chk("reload_tick", tick[0], (k == 6));
    end

    // sync aligns periods 3 and 7
    set_period(0, 3); set_period(1, 7); load = 2'b11; en = 2'b11;
    cycle();
    load = '0;
    repeat (5) cycle();
    sync = 1'b1;
    cycle();
    chk("sync_clk_out", clk_out, 0);
    chk("sync_tick", tick, 0);
    sync = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      cycle();
      chk("sync_phase_tick", tick, {(k % 8 == 0), (k % 4 == 0)});
    end

    // asynchronous reset between edges
    repeat (2) cycle();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_tick", tick, 0);
    chk("async_rst_ack", step_ack, 0);
    chk("async_rst_clk_out", clk_out, 0);
    cycle();
    rst = 1'b0;
    for (int k = 1; k <= int'(PR) + 1; k++) begin
      cycle();
      chk("post_rst_tick", tick, (k == int'(PR) + 1) ? 2'b11 : 2'b00);
    end

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < CH; i++) begin
        en[i]       = ($urandom_range(0, 3) != 0);
        step_req[i] = ($urandom_range(0, 2) == 0);
        load[i]     = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 9) == 0) mode[i] = ~mode[i];
        set_period(i, $urandom_range(0, 9));
      end
      sync = ($urandom_range(0, 19) == 0);
      cycle();
    end

    en = '0; load = '0; sync = 1'b0; step_req = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
